// File: rtl/irq_arbiter_pkg.sv
// Shared types and constants for the interrupt arbiter: FSM state encoding,
// default watchdog limit and an index-width helper.
package irq_arbiter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_SACK = 3'd2,
      ST_INTR = 3'd3,
      ST_DONE = 3'd4
   } irq_state_t;

   localparam int WDOG_CYC_DEFAULT = 1023;

   // A single device still needs a one-bit index.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/irq_prienc.sv
// Fixed-priority encoder: reports the lowest-numbered set request bit and
// whether any bit is set. Index 0 has the highest priority.
module irq_prienc
   import irq_arbiter_pkg::*;
#(
   parameter int NDEV = 4,
   parameter int IDXW = idx_width(NDEV)
) (
   input  logic [NDEV-1:0] req,
   output logic [IDXW-1:0] idx,
   output logic            valid
);

   // Scan from the top down so the lowest set index is the last one written.
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int i = NDEV - 1; i >= 0; i--) begin
         idx   = req[i] ? IDXW'(i) : idx;
         valid = valid | req[i];
      end
   end

endmodule

// File: rtl/irq_arbiter.sv
// Bus interrupt arbiter: latches the highest-priority device request and runs
// the BR/BG/SACK/INTR/SSYN handshake. Optional watchdog: IRQ_ARBITER_WATCHDOG_EN.
module irq_arbiter
   import irq_arbiter_pkg::*;
#(
   parameter int NDEV     = 4,
   parameter int WDOG_CYC = WDOG_CYC_DEFAULT
) (
   input  logic              CLOCK,
   input  logic              RESET,
   input  logic              init_in_h,
   input  logic [NDEV-1:0]   intreq_in,
   input  logic [NDEV*8-1:0] irvec_in,
   output logic              intgnt,
   output logic [7:0]        igvec,
   output logic              bus_br_out_h,
   input  logic              bus_bg_in_h,
   output logic              bus_sack_out_h,
   output logic              bus_intr_out_h,
   output logic [15:0]       bus_d_out_h,
   input  logic              bus_ssyn_in_h,
   output logic              wdog_err
);

   localparam int IDXW = idx_width(NDEV);

   irq_state_t      state;
   irq_state_t      nstate;
   logic [IDXW-1:0] win;
   logic [IDXW-1:0] nwin;
   logic [7:0]      vec;
   logic [7:0]      nvec;
   logic [IDXW-1:0] pe_idx;
   logic            pe_valid;
   logic            grant;
   logic            wdog_hit;
   logic            clr;

   assign clr = RESET | init_in_h;

   irq_prienc #(
      .NDEV (NDEV),
      .IDXW (IDXW)
   ) u_prienc (
      .req   (intreq_in),
      .idx   (pe_idx),
      .valid (pe_valid)
   );

   // Next-state logic; win/vec only move while IDLE so later requests cannot pre-empt.
   always_comb begin
      nstate = state;
      nwin   = win;
      nvec   = vec;
      grant  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (pe_valid) begin
               nwin   = pe_idx;
               nvec   = irvec_in[8*int'(pe_idx) +: 8];
               nstate = ST_REQ;
            end else begin
               nstate = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (!intreq_in[win]) begin
               nstate = ST_IDLE;
            end else if (bus_bg_in_h) begin
               nstate = ST_SACK;
            end else begin
               nstate = ST_REQ;
            end
         end
         ST_SACK: begin
            if (!intreq_in[win]) begin
               nstate = ST_IDLE;
            end else if (!bus_bg_in_h) begin
               nstate = ST_INTR;
            end else begin
               nstate = ST_SACK;
            end
         end
         ST_INTR: begin
            if (bus_ssyn_in_h) begin
               grant  = 1'b1;
               nstate = ST_DONE;
            end else if (wdog_hit) begin
               nstate = ST_DONE;
            end else begin
               nstate = ST_INTR;
            end
         end
         ST_DONE: begin
            if (!bus_ssyn_in_h) begin
               nstate = ST_IDLE;
            end else begin
               nstate = ST_DONE;
            end
         end
         default: begin
            nstate = ST_IDLE;
         end
      endcase
   end

   // The grant pulse must coincide with the SSYN cycle, so it cannot be registered.
   assign intgnt = grant & ~clr;
   assign igvec  = vec;

   // State register and bus outputs, registered from the next state so they track the FSM.
   always_ff @(posedge CLOCK) begin
      if (clr) begin
         state          <= ST_IDLE;
         win            <= '0;
         vec            <= 8'h00;
         bus_br_out_h   <= 1'b0;
         bus_sack_out_h <= 1'b0;
         bus_intr_out_h <= 1'b0;
         bus_d_out_h    <= 16'h0000;
      end else begin
         state          <= nstate;
         win            <= nwin;
         vec            <= nvec;
         bus_br_out_h   <= (nstate == ST_REQ);
         bus_sack_out_h <= (nstate == ST_SACK) || (nstate == ST_INTR);
         bus_intr_out_h <= (nstate == ST_INTR);
         bus_d_out_h    <= (nstate == ST_INTR) ? {8'h00, nvec} : 16'h0000;
      end
   end

`ifdef IRQ_ARBITER_WATCHDOG_EN
   localparam int WCW = $clog2(WDOG_CYC + 1);

   logic [WCW-1:0] wdog_cnt;

   // Counter holds the number of INTR cycles already spent without SSYN.
   assign wdog_hit = (wdog_cnt == WCW'(WDOG_CYC - 1));

   // INTR dwell counter, cleared whenever the FSM is outside INTR.
   always_ff @(posedge CLOCK) begin
      if (clr) begin
         wdog_cnt <= '0;
      end else if ((state == ST_INTR) && (nstate == ST_INTR)) begin
         wdog_cnt <= wdog_cnt + WCW'(1);
      end else begin
         wdog_cnt <= '0;
      end
   end

   // Sticky error flag; bus INIT deliberately leaves it alone.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         wdog_err <= 1'b0;
      end else if (!init_in_h && (state == ST_INTR) && !bus_ssyn_in_h && wdog_hit) begin
         wdog_err <= 1'b1;
      end else begin
         wdog_err <= wdog_err;
      end
   end
`else
   assign wdog_hit = 1'b0;
   assign wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_irq_arbiter.sv
// Self-checking bench for irq_arbiter: directed vector table, hand sequences
// for cancel/INIT/watchdog, and randomized traffic against a behavioural model.
module tb_irq_arbiter;

   localparam int NDEV = 4;
   localparam int WDOG = 1023;
`ifdef IRQ_ARBITER_WATCHDOG_EN
   localparam bit WD_EN = 1'b1;
`else
   localparam bit WD_EN = 1'b0;
`endif

   logic        CLOCK = 1'b0;
   logic        RESET;
   logic        init_in_h;
   logic [3:0]  intreq_in;
   logic [31:0] irvec_in;
   logic        intgnt;
   logic [7:0]  igvec;
   logic        bus_br_out_h;
   logic        bus_bg_in_h;
   logic        bus_sack_out_h;
   logic        bus_intr_out_h;
   logic [15:0] bus_d_out_h;
   logic        bus_ssyn_in_h;
   logic        wdog_err;

   int errors = 0;
   int checks = 0;

   always #5 CLOCK = ~CLOCK;

   irq_arbiter #(.NDEV(NDEV), .WDOG_CYC(WDOG)) dut (
      .CLOCK          (CLOCK),
      .RESET          (RESET),
      .init_in_h      (init_in_h),
      .intreq_in      (intreq_in),
      .irvec_in       (irvec_in),
      .intgnt         (intgnt),
      .igvec          (igvec),
      .bus_br_out_h   (bus_br_out_h),
      .bus_bg_in_h    (bus_bg_in_h),
      .bus_sack_out_h (bus_sack_out_h),
      .bus_intr_out_h (bus_intr_out_h),
      .bus_d_out_h    (bus_d_out_h),
      .bus_ssyn_in_h  (bus_ssyn_in_h),
      .wdog_err       (wdog_err)
   );

   typedef struct packed {
      logic [3:0] req;
      logic       bg;
      logic       ss;
      logic       br;
      logic       sack;
      logic       intr;
      logic [7:0] d;
      logic       gnt;
      logic [7:0] ig;
   } vec_t;

   vec_t tbl [0:28];

   function automatic logic [28:0] obs();
      return {bus_br_out_h, bus_sack_out_h, bus_intr_out_h, bus_d_out_h,
              intgnt, igvec, wdog_err};
   endfunction

   function automatic logic [28:0] pack_exp(input logic br, input logic sack, input logic intr,
                                            input logic [15:0] d, input logic gnt,
                                            input logic [7:0] ig, input logic err);
      return {br, sack, intr, d, gnt, ig, err};
   endfunction

   task automatic check(input string name, input logic [28:0] act, input logic [28:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (br,sack,intr,d,gnt,igvec,err)", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLOCK);
      #1;
   endtask

   // Behavioural reference model state
   bit       m_busy, m_bg_seen, m_intr, m_done, m_err;
   int       m_win, m_wd;
   bit [7:0] m_vec;

   task automatic model_release();
      m_busy = 1'b0; m_bg_seen = 1'b0; m_intr = 1'b0; m_done = 1'b0; m_wd = 0;
   endtask

   task automatic model_step();
      int r;
      if (RESET || init_in_h) begin
         model_release();
         m_vec = 8'h00;
         m_win = 0;
         if (RESET) m_err = 1'b0;
      end else if (!m_busy) begin
         if (intreq_in != 4'b0000) begin
            r      = int'(intreq_in);
            m_win  = $clog2(r & (-r));
            m_vec  = irvec_in[8*m_win +: 8];
            m_busy = 1'b1;
         end
      end else if (m_done) begin
         if (!bus_ssyn_in_h) model_release();
      end else if (m_intr) begin
         if (bus_ssyn_in_h) begin
            m_done = 1'b1;
         end else begin
            m_wd++;
            if (WD_EN && m_wd == WDOG) begin
               m_done = 1'b1;
               m_err  = 1'b1;
            end
         end
      end else if (!intreq_in[m_win]) begin
         model_release();
      end else if (m_bg_seen) begin
         if (!bus_bg_in_h) begin
            m_intr = 1'b1;
            m_wd   = 0;
         end
      end else if (bus_bg_in_h) begin
         m_bg_seen = 1'b1;
      end
   endtask

   function automatic logic [28:0] model_out();
      logic br, sack, intr, gnt;
      br   = m_busy && !m_bg_seen;
      sack = m_busy && m_bg_seen && !m_done;
      intr = m_busy && m_intr && !m_done;
      gnt  = intr && bus_ssyn_in_h && !RESET && !init_in_h;
      return pack_exp(br, sack, intr, intr ? {8'h00, m_vec} : 16'h0000, gnt, m_vec, m_err);
   endfunction

   task automatic enter_intr(input logic [3:0] req);
      intreq_in = req; bus_bg_in_h = 1'b0; bus_ssyn_in_h = 1'b0;
      tick();
      bus_bg_in_h = 1'b1;
      tick();
      bus_bg_in_h = 1'b0;
      tick();
   endtask

   initial begin
      int  n;
      bit  gnt_seen;
      logic exp_err;

      RESET = 1'b1; init_in_h = 1'b0; intreq_in = 4'b0000;
      bus_bg_in_h = 1'b0; bus_ssyn_in_h = 1'b0;
      irvec_in = {8'h33, 8'o310, 8'h22, 8'h11};

      //                req      bg    ss    br    sack  intr  d      gnt   igvec
      tbl[0]  = '{4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
      tbl[1]  = '{4'b0100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'o310};
      tbl[2]  = '{4'b0100, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'o310};
      tbl[3]  = '{4'b0100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'o310};
      tbl[4]  = '{4'b0100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'o310};
      tbl[5]  = '{4'b0100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'o310, 1'b0, 8'o310};
      tbl[6]  = '{4'b0100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'o310, 1'b1, 8'o310};
      tbl[7]  = '{4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'o310};
      tbl[8]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'o310};
      tbl[9]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'o310};
      tbl[10] = '{4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'o310};
      tbl[11] = '{4'b1010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h22};
      tbl[12] = '{4'b1010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h22};
      tbl[13] = '{4'b1010, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1, 8'h22};
      tbl[14] = '{4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h22};
      tbl[15] = '{4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h22};
      tbl[16] = '{4'b1001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h33};
      tbl[17] = '{4'b1001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h33};
      tbl[18] = '{4'b1001, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h33, 1'b1, 8'h33};
      tbl[19] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h33};
      tbl[20] = '{4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h33};
      tbl[21] = '{4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h11};
      tbl[22] = '{4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h11};
      tbl[23] = '{4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h11};
      tbl[24] = '{4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h11};
      tbl[25] = '{4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h22};
      tbl[26] = '{4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h22};
      tbl[27] = '{4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h22};
      tbl[28] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h22};

      tick();
      tick();
      RESET = 1'b0;

      // Directed table: inputs held for one cycle, outputs checked before the edge
      for (int i = 0; i <= 28; i++) begin
         intreq_in     = tbl[i].req;
         bus_bg_in_h   = tbl[i].bg;
         bus_ssyn_in_h = tbl[i].ss;
         #2;
         check($sformatf("table[%0d]", i), obs(),
               pack_exp(tbl[i].br, tbl[i].sack, tbl[i].intr, {8'h00, tbl[i].d},
                        tbl[i].gnt, tbl[i].ig, 1'b0));
         tick();
      end

      // Watchdog: SSYN withheld in INTR
      enter_intr(4'b0100);
      n = 0;
      gnt_seen = 1'b0;
      while (bus_intr_out_h && n < 1100) begin
         if (intgnt) gnt_seen = 1'b1;
         n++;
         tick();
      end
      check_int("wdog_no_gnt", int'(gnt_seen), 0);
`ifdef IRQ_ARBITER_WATCHDOG_EN
      exp_err = 1'b1;
      check_int("wdog_intr_cycles", n, WDOG);
      check("wdog_done", obs(), pack_exp(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 8'o310, 1'b1));
      intreq_in = 4'b0000;
      tick();
`else
      exp_err = 1'b0;
      check_int("intr_waits", n, 1100);
      check("intr_still", obs(), pack_exp(1'b0, 1'b1, 1'b1, 16'o000310, 1'b0, 8'o310, 1'b0));
      bus_ssyn_in_h = 1'b1;
      #2;
      check_int("late_ssyn_gnt", int'(intgnt), 1);
      tick();
      bus_ssyn_in_h = 1'b0;
      intreq_in = 4'b0000;
      tick();
`endif
      tick();

      // INIT in the middle of INTR
      enter_intr(4'b0100);
      check("init_pre", obs(), pack_exp(1'b0, 1'b1, 1'b1, 16'o000310, 1'b0, 8'o310, exp_err));
      init_in_h = 1'b1;
      tick();
      init_in_h = 1'b0;
      intreq_in = 4'b0000;
      check("init_clear", obs(), pack_exp(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, exp_err));
      tick();
      check("init_idle", obs(), pack_exp(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, exp_err));
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      check("reset_clear", obs(), pack_exp(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0));

      // Randomized traffic against the behavioural model
      model_release();
      m_vec = 8'h00; m_win = 0; m_err = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         RESET     = ($urandom_range(0, 299) == 0);
         init_in_h = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 7) == 0) intreq_in = 4'($urandom_range(0, 15));
         irvec_in      = $urandom;
         bus_bg_in_h   = ($urandom_range(0, 1) == 0);
         bus_ssyn_in_h = ($urandom_range(0, 1) == 0);
         #2;
         check($sformatf("rand[%0d]", c), obs(), model_out());
         model_step();
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
